// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds the default address/data widths, the special write addresses
// (hi, lo, zero), the address-space decode helpers and the enum that
// names which source owns the regwrite port in a given cycle.
package regfile_write_arbiter_pkg;

  localparam int RF_AW = 7;
  localparam int RF_DW = 32;

  localparam logic [RF_AW-1:0] ADDR_HI   = 7'h7F;
  localparam logic [RF_AW-1:0] ADDR_LO   = 7'h40;
  localparam logic [RF_AW-1:0] ADDR_ZERO = 7'h00;

  // Which source drives the regwrite port in the current decision cycle
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO,
    SRC_LSU
  } wrSrc_e;

  // Writes to the zero register are swallowed by the arbiter
  function automatic logic isZeroAddr(input logic [RF_AW-1:0] addr);
    return addr == ADDR_ZERO;
  endfunction

  // Exact hi or lo destination; these collide with the MDU hl port
  function automatic logic isHiLoAddr(input logic [RF_AW-1:0] addr);
    return (addr == ADDR_HI) || (addr == ADDR_LO);
  endfunction

  // Bit 6 clear and bit 5 set selects the CP0 space
  function automatic logic isCp0Addr(input logic [RF_AW-1:0] addr);
    return !addr[6] && addr[5];
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_ret_fifo.sv
// wb_ret_fifo: small FIFO buffering late load returns until the regwrite
// port is free. Every entry carries a valid bit that a younger pipeline
// write to the same address can clear, so stale loads drain without
// issuing.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push_i            write one entry (caller guarantees not full)
//   pushValid_i       valid bit stored with the pushed entry
//   pushAddr_i/Data_i payload of the pushed entry
//   pop_i             drop the head entry (caller guarantees not empty)
//   squash_i          clear valid on every entry whose addr matches
//   squashAddr_i      address used for the squash match
//   full_o, empty_o   occupancy flags from registered pointers
//   headValid_o/Addr_o/Data_o  current head entry
module wb_ret_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pushValid_i,
  input  logic [AW-1:0] pushAddr_i,
  input  logic [DW-1:0] pushData_i,
  input  logic          pop_i,
  input  logic          squash_i,
  input  logic [AW-1:0] squashAddr_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          headValid_o,
  output logic [AW-1:0] headAddr_o,
  output logic [DW-1:0] headData_o
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [PW:0]      wrPtr_q, rdPtr_q;
  logic [DEPTH-1:0] entValid_q;
  logic [AW-1:0]    entAddr_q [DEPTH];
  logic [DW-1:0]    entData_q [DEPTH];

  assign empty_o     = (wrPtr_q == rdPtr_q);
  assign full_o      = (wrPtr_q[PW] != rdPtr_q[PW]) &&
                       (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
  assign headValid_o = entValid_q[rdPtr_q[PW-1:0]];
  assign headAddr_o  = entAddr_q[rdPtr_q[PW-1:0]];
  assign headData_o  = entData_q[rdPtr_q[PW-1:0]];

  // Squash runs over all slots; the freshly pushed slot is written after it,
  // and its valid bit already accounts for any same-cycle squash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      entValid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entAddr_q[i] <= '0;
        entData_q[i] <= '0;
      end
    end else begin
      if (squash_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entAddr_q[i] == squashAddr_i) begin
            entValid_q[i] <= 1'b0;
          end
        end
      end
      if (push_i) begin
        entValid_q[wrPtr_q[PW-1:0]] <= pushValid_i;
        entAddr_q[wrPtr_q[PW-1:0]]  <= pushAddr_i;
        entData_q[wrPtr_q[PW-1:0]]  <= pushData_i;
        wrPtr_q                     <= wrPtr_q + 1'b1;
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: sole owner of the register-file write side.
// Merges the in-order WB stage (top priority, never stalled), late load
// returns (buffered in wb_ret_fifo) and 64-bit MDU hi/lo results (1-entry
// holding register). All register-file outputs are registered: a decision
// made in cycle N is presented in cycle N+1 for exactly one cycle.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   pipe_we/addr/data             WB-stage write, accepted every cycle
//   lsu_valid/ready/addr/data     late load return handshake
//   mdu_valid/ready/data          MDU {hi,lo} result handshake
//   regwrite/write_addr/write_data  register_file GPR/CP0/hi-lo write port
//   hl_we/hl_data                 register_file combined hi/lo write port
//   lsu_pend                      load return FIFO is non-empty
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int LSU_DEPTH = 2,
  parameter int AW        = RF_AW,
  parameter int DW        = RF_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_we,
  input  logic [AW-1:0]   pipe_addr,
  input  logic [DW-1:0]   pipe_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [2*DW-1:0] mdu_data,
  output logic            regwrite,
  output logic [AW-1:0]   write_addr,
  output logic [DW-1:0]   write_data,
  output logic            hl_we,
  output logic [2*DW-1:0] hl_data,
  output logic            lsu_pend
);

  logic            fifoFull, fifoEmpty;
  logic            headValid;
  logic [AW-1:0]   headAddr;
  logic [DW-1:0]   headData;

  logic            pipeBusy, hlBlocked;
  logic            lsuAccept, mduAccept;
  logic            popHead, bypassLsu, pushLsu, pushValid;
  wrSrc_e          wrSrc;

  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   writeAddr_q, writeAddr_d;
  logic [DW-1:0]   writeData_q, writeData_d;
  logic            hlWe_q, hlWe_d;
  logic [2*DW-1:0] hlData_q, hlData_d;
  logic            holdValid_q, holdValid_d;
  logic [2*DW-1:0] holdData_q, holdData_d;

  // Ready flags depend on registered state only
  assign lsu_ready = !fifoFull;
  assign mdu_ready = !holdValid_q;
  assign lsu_pend  = !fifoEmpty;

  assign regwrite   = regwrite_q;
  assign write_addr = writeAddr_q;
  assign write_data = writeData_q;
  assign hl_we      = hlWe_q;
  assign hl_data    = hlData_q;

  wb_ret_fifo #(
    .DEPTH (LSU_DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (pushLsu),
    .pushValid_i  (pushValid),
    .pushAddr_i   (lsu_addr),
    .pushData_i   (lsu_data),
    .pop_i        (popHead),
    .squash_i     (pipeBusy),
    .squashAddr_i (pipe_addr),
    .full_o       (fifoFull),
    .empty_o      (fifoEmpty),
    .headValid_o  (headValid),
    .headAddr_o   (headAddr),
    .headData_o   (headData)
  );

  // A pipe write to the zero register is dropped and leaves the port free
  // for the FIFO. A load accepted while the port is free and the FIFO is
  // empty skips the FIFO. A load pushed in the same cycle as a pipe write
  // to its address is already stale, so it enters the FIFO invalid.
  always_comb begin
    pipeBusy  = pipe_we && !isZeroAddr(pipe_addr);
    hlBlocked = pipe_we && isHiLoAddr(pipe_addr);
    lsuAccept = lsu_valid && lsu_ready;
    mduAccept = mdu_valid && mdu_ready;
    popHead   = !pipeBusy && !fifoEmpty;
    bypassLsu = !pipeBusy && fifoEmpty && lsuAccept;
    pushLsu   = lsuAccept && !bypassLsu;
    pushValid = !(pipeBusy && (lsu_addr == pipe_addr));

    wrSrc = SRC_NONE;
    if (pipeBusy) begin
      wrSrc = SRC_PIPE;
    end else if (popHead) begin
      wrSrc = SRC_FIFO;
    end else if (bypassLsu) begin
      wrSrc = SRC_LSU;
    end
  end

  // Regwrite port next state; squashed or zero-address entries still pop
  // but present nothing.
  always_comb begin
    regwrite_d  = 1'b0;
    writeAddr_d = '0;
    writeData_d = '0;
    case (wrSrc)
      SRC_PIPE: begin
        regwrite_d  = 1'b1;
        writeAddr_d = pipe_addr;
        writeData_d = pipe_data;
      end
      SRC_FIFO: begin
        if (headValid && !isZeroAddr(headAddr)) begin
          regwrite_d  = 1'b1;
          writeAddr_d = headAddr;
          writeData_d = headData;
        end
      end
      SRC_LSU: begin
        if (!isZeroAddr(lsu_addr)) begin
          regwrite_d  = 1'b1;
          writeAddr_d = lsu_addr;
          writeData_d = lsu_data;
        end
      end
      default: begin
      end
    endcase
  end

  // hl port: a held result goes first; a new result bypasses the holding
  // register when nothing blocks it. A pipe mthi/mtlo blocks the hl port so
  // the MDU result lands after it.
  always_comb begin
    hlWe_d      = 1'b0;
    hlData_d    = '0;
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    if (holdValid_q) begin
      if (!hlBlocked) begin
        hlWe_d      = 1'b1;
        hlData_d    = holdData_q;
        holdValid_d = 1'b0;
      end
    end else if (mduAccept) begin
      if (!hlBlocked) begin
        hlWe_d   = 1'b1;
        hlData_d = mdu_data;
      end else begin
        holdValid_d = 1'b1;
        holdData_d  = mdu_data;
      end
    end
  end

  // Output and holding registers; reset clears them immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      writeAddr_q <= '0;
      writeData_q <= '0;
      hlWe_q      <= 1'b0;
      hlData_q    <= '0;
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      writeAddr_q <= writeAddr_d;
      writeData_q <= writeData_d;
      hlWe_q      <= hlWe_d;
      hlData_q    <= hlData_d;
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: hand-computed vectors for the
// pipe path, FIFO fill/drain, WAW squash, hi/lo ordering, zero-address
// drops, load/MDU bypass and asynchronous reset.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [6:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [6:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [63:0] mdu_data;
  logic        regwrite;
  logic [6:0]  write_addr;
  logic [31:0] write_data;
  logic        hl_we;
  logic [63:0] hl_data;
  logic        lsu_pend;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_addr   (lsu_addr),
    .lsu_data   (lsu_data),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_data   (mdu_data),
    .regwrite   (regwrite),
    .write_addr (write_addr),
    .write_data (write_data),
    .hl_we      (hl_we),
    .hl_data    (hl_data),
    .lsu_pend   (lsu_pend)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on failure
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive all request inputs in one go
  task automatic applyStimulus(input logic pWe, input logic [6:0] pAddr, input logic [31:0] pData,
                               input logic lValid, input logic [6:0] lAddr, input logic [31:0] lData,
                               input logic mValid, input logic [63:0] mData);
    pipe_we   = pWe;
    pipe_addr = pAddr;
    pipe_data = pData;
    lsu_valid = lValid;
    lsu_addr  = lAddr;
    lsu_data  = lData;
    mdu_valid = mValid;
    mdu_data  = mData;
  endtask

  // Advance past the next rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 0, 0, 64'h0);
    #12;
    checkOutput("rst_regwrite", 64'(regwrite), 64'h0);
    checkOutput("rst_hl_we", 64'(hl_we), 64'h0);
    checkOutput("rst_lsu_pend", 64'(lsu_pend), 64'h0);
    rst = 1'b0;
    #1;
    checkOutput("rst_lsu_ready", 64'(lsu_ready), 64'h1);
    checkOutput("rst_mdu_ready", 64'(mdu_ready), 64'h1);
    tick();

    $display("[TB] pipe write");
    applyStimulus(1, 7'd5, 32'h11, 0, 7'h00, 0, 0, 64'h0);
    tick();
    checkOutput("t1_regwrite", 64'(regwrite), 64'h1);
    checkOutput("t1_addr", 64'(write_addr), 64'h5);
    checkOutput("t1_data", 64'(write_data), 64'h11);
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 0, 0, 64'h0);
    tick();
    checkOutput("t1_one_cycle", 64'(regwrite), 64'h0);

    $display("[TB] fifo fill and drain");
    applyStimulus(1, 7'd10, 32'h100, 1, 7'd3, 32'h33, 0, 64'h0);
    tick();
    checkOutput("t2_pipe_addr0", 64'(write_addr), 64'd10);
    checkOutput("t2_pend1", 64'(lsu_pend), 64'h1);
    checkOutput("t2_ready1", 64'(lsu_ready), 64'h1);
    applyStimulus(1, 7'd11, 32'h101, 1, 7'd4, 32'h44, 0, 64'h0);
    tick();
    checkOutput("t2_full_ready", 64'(lsu_ready), 64'h0);
    checkOutput("t2_pipe_addr1", 64'(write_addr), 64'd11);
    applyStimulus(1, 7'd12, 32'h102, 0, 7'h00, 0, 0, 64'h0);
    tick();
    applyStimulus(1, 7'd13, 32'h103, 0, 7'h00, 0, 0, 64'h0);
    tick();
    checkOutput("t2_pipe_addr3", 64'(write_addr), 64'd13);
    checkOutput("t2_still_full", 64'(lsu_ready), 64'h0);
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 0, 0, 64'h0);
    tick();
    checkOutput("t2_drain0_we", 64'(regwrite), 64'h1);
    checkOutput("t2_drain0_addr", 64'(write_addr), 64'd3);
    checkOutput("t2_drain0_data", 64'(write_data), 64'h33);
    tick();
    checkOutput("t2_drain1_addr", 64'(write_addr), 64'd4);
    checkOutput("t2_drain1_data", 64'(write_data), 64'h44);
    checkOutput("t2_pend0", 64'(lsu_pend), 64'h0);
    checkOutput("t2_ready_back", 64'(lsu_ready), 64'h1);
    tick();
    checkOutput("t2_idle", 64'(regwrite), 64'h0);

    $display("[TB] WAW squash");
    applyStimulus(1, 7'd9, 32'h99, 1, 7'd8, 32'hAA, 0, 64'h0);
    tick();
    checkOutput("t3_pend", 64'(lsu_pend), 64'h1);
    applyStimulus(1, 7'd8, 32'hBB, 0, 7'h00, 0, 0, 64'h0);
    tick();
    checkOutput("t3_pipe_addr", 64'(write_addr), 64'd8);
    checkOutput("t3_pipe_data", 64'(write_data), 64'hBB);
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 0, 0, 64'h0);
    tick();
    checkOutput("t3_squashed_we", 64'(regwrite), 64'h0);
    checkOutput("t3_pend_drop", 64'(lsu_pend), 64'h0);

    $display("[TB] hi/lo ordering");
    applyStimulus(1, 7'h7F, 32'h55, 0, 7'h00, 0, 1, 64'h00000001_00000002);
    tick();
    checkOutput("t4_pipe_hi_we", 64'(regwrite), 64'h1);
    checkOutput("t4_pipe_hi_addr", 64'(write_addr), 64'h7F);
    checkOutput("t4_hl_wait", 64'(hl_we), 64'h0);
    checkOutput("t4_mdu_held", 64'(mdu_ready), 64'h0);
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 0, 0, 64'h0);
    tick();
    checkOutput("t4_hl_we", 64'(hl_we), 64'h1);
    checkOutput("t4_hl_data", hl_data, 64'h00000001_00000002);
    checkOutput("t4_no_regwrite", 64'(regwrite), 64'h0);
    tick();
    checkOutput("t4_hl_one_cycle", 64'(hl_we), 64'h0);
    checkOutput("t4_mdu_ready", 64'(mdu_ready), 64'h1);
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 0, 1, 64'hDEAD0000_0000BEEF);
    tick();
    checkOutput("t4_bypass_we", 64'(hl_we), 64'h1);
    checkOutput("t4_bypass_data", hl_data, 64'hDEAD0000_0000BEEF);
    checkOutput("t4_bypass_ready", 64'(mdu_ready), 64'h1);

    $display("[TB] zero address and load bypass");
    applyStimulus(0, 7'h00, 0, 1, 7'h00, 32'h77, 0, 64'h0);
    #1;
    checkOutput("t5_ready", 64'(lsu_ready), 64'h1);
    tick();
    checkOutput("t5_zero_we", 64'(regwrite), 64'h0);
    checkOutput("t5_zero_pend", 64'(lsu_pend), 64'h0);
    applyStimulus(0, 7'h00, 0, 1, 7'd6, 32'h66, 0, 64'h0);
    tick();
    checkOutput("t5_bypass_we", 64'(regwrite), 64'h1);
    checkOutput("t5_bypass_addr", 64'(write_addr), 64'd6);
    checkOutput("t5_bypass_data", 64'(write_data), 64'h66);
    checkOutput("t5_bypass_pend", 64'(lsu_pend), 64'h0);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 7'h40, 32'h1, 1, 7'd21, 32'h21, 1, 64'h3_4);
    tick();
    applyStimulus(1, 7'h7F, 32'h2, 1, 7'd22, 32'h22, 0, 64'h0);
    tick();
    checkOutput("t6_full", 64'(lsu_ready), 64'h0);
    checkOutput("t6_held", 64'(mdu_ready), 64'h0);
    checkOutput("t6_regwrite", 64'(regwrite), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_we", 64'(regwrite), 64'h0);
    checkOutput("t6_async_addr", 64'(write_addr), 64'h0);
    checkOutput("t6_async_pend", 64'(lsu_pend), 64'h0);
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 0, 0, 64'h0);
    #2;
    rst = 1'b0;
    tick();
    checkOutput("t6_lsu_ready", 64'(lsu_ready), 64'h1);
    checkOutput("t6_mdu_ready", 64'(mdu_ready), 64'h1);
    checkOutput("t6_no_stale_we", 64'(regwrite), 64'h0);
    checkOutput("t6_no_stale_hl", 64'(hl_we), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
